bp_be_rec_to_fp_pipe: RTL and testbench
=======================================

# bp_be_rec_to_fp_pipe

Two-stage, valid/ready-pipelined converter from the 65-bit recoded floating-point format (hardfloat, dp-width container) back to raw IEEE-754 bits. It sits between the FP register file/FPU result path and the integer-side consumers: FP stores, FMV.X.W/FMV.X.D, and the memory write path. It handles the inverse of the SP-in-DP recoded encoding and NaN-boxes single-precision results. Throughput is one conversion per cycle, with full backpressure and a flush.

## Interface
- bp_params_p, e_bp_default_cfg, processor configuration; supplies dword_width_p=64, word_width_p=32 and the dp/sp hardfloat widths.
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- flush_i  in  1  kills all in-flight entries.
- v_i  in  1  input valid.
- ready_o  out  1  input can be accepted this cycle.
- rec_i  in  65  recoded value: sign[64], exp[63:52] (12b), fract[51:0].
- rec_sp_not_dp_i  in  1  rec_i holds an SP-origin value in dp container; output is SP NaN-boxed.
- v_o  out  1  output valid.
- ready_i  in  1  consumer accepts output.
- raw_o  out  64  raw IEEE bits.
- raw_sp_not_dp_o  out  1  precision of raw_o.

## Operation
- Handshake: input transfer when v_i & ready_o. Output transfer when v_o & ready_i.
- Stage 1 register (s1) captures {rec_i, rec_sp_not_dp_i}. It then performs the unsafe downconvert combinationally.
  - code = exp[11:9].
  - special = (code==0) | (code>=6).
  - sp_exp[8:0] = special ? {code, exp[5:0]} : (exp − 1792)[8:0], where 1792 = 2^11 − 2^8.
  - sp_fract = fract[51:29].
  - sign passes through.
- The downconvert is the exact inverse of the raw→recoded SP upconvert: rec→raw(up(x)) == x for all 2^32 SP patterns.
- Stage 2 register (s2) captures the fully converted raw result.
  - SP: recFNToFN(8,24) on {sign, sp_exp, sp_fract}, giving raw_o = {32'hFFFF_FFFF, sp_raw}.
  - DP: recFNToFN(11,53) on rec_i, giving raw_o = dp_raw.
- NaN payloads and signs are preserved bit-exactly; there is no canonicalization.
- Pipeline control:
  - s2_adv = ~s2_v | ready_i.
  - s1_adv = ~s1_v | s2_adv.
  - ready_o = s1_adv.
  - s2 loads from s1 when s1_v & s2_adv.
  - s2_v clears when its output transfers and nothing new loads.
- Data registers are not reset. Only valids are reset.
- Flush: on a flush_i edge, s1_v and s2_v are cleared. Any input presented that cycle is dropped (ready_o may be high, but the entry is discarded). flush_i has priority over all loads.

## Timing
- Reset: on the first edge with reset_n_i=0, s1_v=s2_v=0. After reset: v_o=0, ready_o=1. raw_o and raw_sp_not_dp_o are don't-care while v_o=0.
- Latency: accepted at edge N, v_o=1 after edge N+1 (visible in cycle N+1), i.e. 2 register stages.
- Throughput: 1/cycle with ready_i held high. Back-to-back inputs emerge in order, one per cycle.
- Backpressure: with ready_i=0, at most 2 entries are buffered (s1, s2), then ready_o=0 combinationally in the same cycle.
  - ready_o depends combinationally on ready_i; there is no combinational v_i→v_o path.
- raw_o and raw_sp_not_dp_o are held stable while v_o & ~ready_i.
- Simultaneous output transfer and input accept when full: allowed; the pipeline shifts and occupancy stays 2.
- Reset mid-operation: it is synchronous and has the same effect as flush; it dominates v_i and flush_i.

## Test plan
- SP 1.0: rec_i=65'h0_8000_0000_0000_0000, sp=1 → after 2 stages raw_o=64'hFFFF_FFFF_3F80_0000, raw_sp_not_dp_o=1. Same rec_i with sp=0 → 64'h3FF0_0000_0000_0000.
- SP specials:
  - +inf: exp=12'hC80, fract=0, sp=1 → 64'hFFFF_FFFF_7F80_0000.
  - −0: sign=1, exp=0, sp=1 → 64'hFFFF_FFFF_8000_0000.
  - qNaN: exp=12'hE00 with fract[51]=1, sp=1 → low word 32'h7FC0_0000.
- Round-trip sweep: for random and edge SP/DP raw values (subnormals 32'h0000_0001 / 64'h1, max-normal, signalling NaNs), feed fNToRecFN+upconvert output in → raw_o equals the original bits, NaN-boxed for SP.
- Backpressure: stream 8 values with ready_i=0 for cycles 2–6 → ready_o falls after 2 accepted entries, no loss or duplication, in-order output, raw_o stable while stalled, full rate after release.
- Flush: 2 entries in flight plus v_i=1 on the flush cycle → next cycle v_o=0, and none of the 3 values ever appears. The next input appears 2 cycles after acceptance.
- Reset: assert reset_n_i=0 for 1 cycle with the pipeline full and ready_i=0 → v_o=0, ready_o=1 the next cycle. Normal operation resumes immediately.

Source files
------------

// File: rtl/bp_be_rec_to_fp_pipe.sv
// Two-stage valid/ready converter from 65-bit recoded (hardfloat) values to raw IEEE-754 bits.
// Stage 1 holds the recoded operand; stage 2 holds the converted, NaN-boxed result.
module bp_be_rec_to_fp_pipe (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        flush_i,
    input  logic        v_i,
    output logic        ready_o,
    input  logic [64:0] rec_i,
    input  logic        rec_sp_not_dp_i,
    output logic        v_o,
    input  logic        ready_i,
    output logic [63:0] raw_o,
    output logic        raw_sp_not_dp_o
);

    // Undo the SP-in-DP exponent rebias; specials keep their 3-bit class code and low exponent bits.
    function automatic logic [32:0] dp_to_sp_rec(input logic [35:0] hi);
        logic [2:0] code;
        logic       special;
        logic [8:0] sp_exp;
        code    = hi[34:32];
        special = (code == 3'd0) | (code >= 3'd6);
        sp_exp  = special ? {code, hi[28:23]} : (hi[31:23] + 9'd256);
        return {hi[35], sp_exp, hi[22:0]};
    endfunction

    function automatic logic [31:0] sp_rec_to_raw(input logic [32:0] rec);
        logic [8:0]  rexp;
        logic [22:0] fract;
        logic        is_zero, is_special, is_nan, is_inf, is_sub;
        logic [4:0]  shift;
        logic [22:0] denorm;
        logic [7:0]  exp_out;
        logic [22:0] fract_out;
        rexp       = rec[31:23];
        fract      = rec[22:0];
        is_zero    = (rexp[8:6] == 3'b000);
        is_special = (rexp[8:7] == 2'b11);
        is_nan     = is_special & rexp[6];
        is_inf     = is_special & ~rexp[6];
        is_sub     = (rexp < 9'd130);
        shift      = 5'd1 - rexp[4:0];
        denorm     = {~is_zero, fract[22:1]} >> shift;
        exp_out    = (is_sub ? 8'd0 : (rexp[7:0] - 8'd129)) | {8{is_nan | is_inf}};
        fract_out  = is_sub ? denorm : (is_inf ? 23'd0 : fract);
        return {rec[32], exp_out, fract_out};
    endfunction

    function automatic logic [63:0] dp_rec_to_raw(input logic [64:0] rec);
        logic [11:0] rexp;
        logic [51:0] fract;
        logic        is_zero, is_special, is_nan, is_inf, is_sub;
        logic [5:0]  shift;
        logic [51:0] denorm;
        logic [10:0] exp_out;
        logic [51:0] fract_out;
        rexp       = rec[63:52];
        fract      = rec[51:0];
        is_zero    = (rexp[11:9] == 3'b000);
        is_special = (rexp[11:10] == 2'b11);
        is_nan     = is_special & rexp[9];
        is_inf     = is_special & ~rexp[9];
        is_sub     = (rexp < 12'd1026);
        shift      = 6'd1 - rexp[5:0];
        denorm     = {~is_zero, fract[51:1]} >> shift;
        exp_out    = (is_sub ? 11'd0 : (rexp[10:0] - 11'd1025)) | {11{is_nan | is_inf}};
        fract_out  = is_sub ? denorm : (is_inf ? 52'd0 : fract);
        return {rec[64], exp_out, fract_out};
    endfunction

    logic        s1_v_q, s1_v_d;
    logic        s2_v_q, s2_v_d;
    logic [64:0] s1_rec_q, s1_rec_d;
    logic        s1_sp_q, s1_sp_d;
    logic [63:0] s2_raw_q, s2_raw_d;
    logic        s2_sp_q, s2_sp_d;
    logic        s1_adv, s2_adv;
    logic [63:0] conv_raw;

    // Pipeline advance, conversion of the stage-1 operand, and next-state selection.
    always_comb begin
        s2_adv = ~s2_v_q | ready_i;
        s1_adv = ~s1_v_q | s2_adv;

        if (s1_sp_q) begin
            conv_raw = {32'hFFFF_FFFF, sp_rec_to_raw(dp_to_sp_rec(s1_rec_q[64:29]))};
        end else begin
            conv_raw = dp_rec_to_raw(s1_rec_q);
        end

        s1_v_d   = s1_v_q;
        s2_v_d   = s2_v_q;
        s1_rec_d = s1_rec_q;
        s1_sp_d  = s1_sp_q;
        s2_raw_d = s2_raw_q;
        s2_sp_d  = s2_sp_q;

        if (flush_i) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_d = v_i;
            end else begin
                s1_v_d = s1_v_q;
            end
            if (s2_adv) begin
                s2_v_d = s1_v_q;
            end else begin
                s2_v_d = s2_v_q;
            end
        end

        if (v_i & s1_adv) begin
            s1_rec_d = rec_i;
            s1_sp_d  = rec_sp_not_dp_i;
        end else begin
            s1_rec_d = s1_rec_q;
            s1_sp_d  = s1_sp_q;
        end

        if (s1_v_q & s2_adv) begin
            s2_raw_d = conv_raw;
            s2_sp_d  = s1_sp_q;
        end else begin
            s2_raw_d = s2_raw_q;
            s2_sp_d  = s2_sp_q;
        end
    end

    // Valid flags: the only reset state in the pipeline.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // Data registers, qualified by the valids and therefore left unreset.
    always_ff @(posedge clk_i) begin
        s1_rec_q <= s1_rec_d;
        s1_sp_q  <= s1_sp_d;
        s2_raw_q <= s2_raw_d;
        s2_sp_q  <= s2_sp_d;
    end

    assign ready_o         = s1_adv;
    assign v_o             = s2_v_q;
    assign raw_o           = s2_raw_q;
    assign raw_sp_not_dp_o = s2_sp_q;

endmodule

// File: tb/tb_bp_be_rec_to_fp_pipe.sv
// Directed bench for bp_be_rec_to_fp_pipe: fixed vectors, round trips, backpressure, flush and reset.
module tb_bp_be_rec_to_fp_pipe;

    logic        clk;
    logic        reset_n_i;
    logic        flush_i;
    logic        v_i;
    logic        ready_o;
    logic [64:0] rec_i;
    logic        rec_sp_not_dp_i;
    logic        v_o;
    logic        ready_i;
    logic [63:0] raw_o;
    logic        raw_sp_not_dp_o;

    int          n_tests;
    int          n_fail;
    logic [64:0] exp_q[$];
    logic [64:0] cur_exp;

    logic [31:0] sp_list [12] = '{32'h0000_0001, 32'h807F_FFFF, 32'h7F7F_FFFF, 32'hFF80_0000,
                                  32'h7F80_0001, 32'hFFBF_FFFF, 32'h0080_0000, 32'h3EAA_AAAB,
                                  32'hC2F6_E979, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [63:0] dp_list [12] = '{64'h0000_0000_0000_0001, 64'h000F_FFFF_FFFF_FFFF,
                                  64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0001,
                                  64'hFFF8_0000_0000_0123, 64'h0010_0000_0000_0000,
                                  64'h3FF0_0000_0000_0000, 64'hC009_21FB_5444_2D18,
                                  64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                                  64'h8008_0000_0000_0000, 64'h4340_0000_0000_0001};

    bp_be_rec_to_fp_pipe dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .flush_i         (flush_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .rec_i           (rec_i),
        .rec_sp_not_dp_i (rec_sp_not_dp_i),
        .v_o             (v_o),
        .ready_i         (ready_i),
        .raw_o           (raw_o),
        .raw_sp_not_dp_o (raw_sp_not_dp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Raw SP bits -> SP recoded -> widened into the DP recoded container.
    function automatic logic [64:0] sp_rec_up(input logic [31:0] r);
        logic [7:0]  e;
        logic [22:0] f;
        logic [22:0] sf;
        logic [8:0]  adj;
        logic [8:0]  rexp;
        logic [2:0]  code;
        logic [11:0] dexp;
        logic        ze, zf, is_zero, is_nan;
        int          nd;
        e  = r[30:23];
        f  = r[22:0];
        ze = (e == 8'd0);
        zf = (f == 23'd0);
        nd = 23;
        for (int i = 0; i < 23; i++) if (f[i]) nd = 22 - i;
        sf      = f << (nd + 1);
        adj     = ze ? ((9'(nd) ^ 9'h1FF) + 9'd130) : ({1'b0, e} + 9'd129);
        is_zero = ze & zf;
        is_nan  = (adj[8:7] == 2'b11) & ~zf;
        rexp    = {(is_zero ? 3'b000 : adj[8:6]) | {2'b00, is_nan}, adj[5:0]};
        code    = rexp[8:6];
        if (code == 3'd0 || code >= 3'd6) dexp = {code, 3'b000, rexp[5:0]};
        else dexp = {3'b000, rexp} + 12'd1792;
        return {r[31], dexp, (ze ? sf : f), 29'd0};
    endfunction

    function automatic logic [64:0] dp_rec(input logic [63:0] r);
        logic [10:0] e;
        logic [51:0] f;
        logic [51:0] sf;
        logic [11:0] adj;
        logic        ze, zf, is_zero, is_nan;
        int          nd;
        e  = r[62:52];
        f  = r[51:0];
        ze = (e == 11'd0);
        zf = (f == 52'd0);
        nd = 52;
        for (int i = 0; i < 52; i++) if (f[i]) nd = 51 - i;
        sf      = f << (nd + 1);
        adj     = ze ? ((12'(nd) ^ 12'hFFF) + 12'd1026) : ({1'b0, e} + 12'd1025);
        is_zero = ze & zf;
        is_nan  = (adj[11:10] == 2'b11) & ~zf;
        return {r[63], (is_zero ? 3'b000 : adj[11:9]) | {2'b00, is_nan}, adj[8:0], (ze ? sf : f)};
    endfunction

    task automatic drive_rec(input logic [64:0] rec, input logic sp, input logic [63:0] raw);
        rec_i           = rec;
        rec_sp_not_dp_i = sp;
        cur_exp         = {sp, raw};
        v_i             = 1'b1;
    endtask

    task automatic drive_sp(input logic [31:0] r);
        drive_rec(sp_rec_up(r), 1'b1, {32'hFFFF_FFFF, r});
    endtask

    task automatic drive_dp(input logic [63:0] r);
        drive_rec(dp_rec(r), 1'b0, r);
    endtask

    // One clock: score the visible output at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        if (v_o) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_v_o", 64'(v_o), 64'd0);
            end else begin
                check_val("raw_o", raw_o, exp_q[0][63:0]);
                check_val("raw_sp_not_dp_o", 64'(raw_sp_not_dp_o), 64'(exp_q[0][64]));
                if (ready_i) void'(exp_q.pop_front());
            end
        end
        if (!reset_n_i || flush_i) exp_q.delete();
        else if (v_i && ready_o) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    logic [64:0] d_rec [5];
    logic        d_sp  [5];
    logic [63:0] d_raw [5];
    int          idx;
    logic        accepted;

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; ready_i = 1'b1;
        rec_i = 65'd0; rec_sp_not_dp_i = 1'b0; cur_exp = 65'd0;
        d_rec[0] = {1'b0, 12'h800, 52'd0};         d_sp[0] = 1'b1; d_raw[0] = 64'hFFFF_FFFF_3F80_0000;
        d_rec[1] = {1'b0, 12'h800, 52'd0};         d_sp[1] = 1'b0; d_raw[1] = 64'h3FF0_0000_0000_0000;
        d_rec[2] = {1'b0, 12'hC80, 52'd0};         d_sp[2] = 1'b1; d_raw[2] = 64'hFFFF_FFFF_7F80_0000;
        d_rec[3] = {1'b1, 12'h000, 52'd0};         d_sp[3] = 1'b1; d_raw[3] = 64'hFFFF_FFFF_8000_0000;
        d_rec[4] = {1'b0, 12'hE00, 1'b1, 51'd0};   d_sp[4] = 1'b1; d_raw[4] = 64'hFFFF_FFFF_7FC0_0000;

        @(posedge clk); #1;
        step();
        check_val("rst_v_o", 64'(v_o), 64'd0);
        check_val("rst_ready_o", 64'(ready_o), 64'd1);
        reset_n_i = 1'b1;

        // Latency of a single SP 1.0 through an empty pipe.
        drive_rec(d_rec[0], d_sp[0], d_raw[0]);
        step();
        v_i = 1'b0; #1;
        check_val("lat_edge_n", 64'(v_o), 64'd0);
        step();
        check_val("lat_edge_n1", 64'(v_o), 64'd1);
        step();

        for (int k = 1; k < 5; k++) begin
            drive_rec(d_rec[k], d_sp[k], d_raw[k]);
            step();
        end
        v_i = 1'b0;
        repeat (3) step();

        // Round trips at full rate: ready_o must stay high.
        for (int k = 0; k < 16; k++) begin
            if (k < 12) drive_sp(sp_list[k]);
            else drive_sp($urandom);
            #1;
            check_val("sweep_sp_ready_o", 64'(ready_o), 64'd1);
            step();
        end
        for (int k = 0; k < 16; k++) begin
            if (k < 12) drive_dp(dp_list[k]);
            else drive_dp({$urandom, $urandom});
            #1;
            check_val("sweep_dp_ready_o", 64'(ready_o), 64'd1);
            step();
        end
        v_i = 1'b0;
        repeat (3) step();

        // Backpressure: consumer stalls for cycles 2..6 while 8 values stream in.
        idx = 0;
        for (int c = 0; c < 17; c++) begin
            ready_i = !(c >= 2 && c <= 6);
            if (idx < 8) begin
                if (idx % 2 == 0) drive_sp(sp_list[idx]);
                else drive_dp(dp_list[idx]);
            end else begin
                v_i = 1'b0;
            end
            #1;
            check_val("bp_ready_o", 64'(ready_o), (c >= 2 && c <= 6) ? 64'd0 : 64'd1);
            check_val("bp_v_o", 64'(v_o), (c >= 2 && c <= 14) ? 64'd1 : 64'd0);
            accepted = v_i && ready_o;
            step();
            if (accepted) idx++;
        end
        check_val("bp_accepted", 64'(idx), 64'd8);

        // Flush with both stages full and a third value offered.
        ready_i = 1'b0;
        drive_sp(sp_list[2]); step();
        drive_dp(dp_list[2]); step();
        drive_sp(sp_list[7]); flush_i = 1'b1; step();
        flush_i = 1'b0; v_i = 1'b0; ready_i = 1'b1; #1;
        check_val("flush_v_o", 64'(v_o), 64'd0);
        check_val("flush_ready_o", 64'(ready_o), 64'd1);
        repeat (3) step();

        // Flush drops an input that handshakes in the same cycle.
        ready_i = 1'b0;
        drive_dp(dp_list[6]); step();
        drive_sp(sp_list[8]); flush_i = 1'b1; #1;
        check_val("flush_accept_ready_o", 64'(ready_o), 64'd1);
        step();
        flush_i = 1'b0; v_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            check_val("flush_idle_v_o", 64'(v_o), 64'd0);
            step();
        end

        drive_dp(dp_list[7]); step();
        v_i = 1'b0; #1;
        check_val("post_flush_lat0", 64'(v_o), 64'd0);
        step();
        check_val("post_flush_lat1", 64'(v_o), 64'd1);
        step();

        // Reset with the pipeline full and the consumer stalled.
        ready_i = 1'b0;
        drive_sp(sp_list[3]); step();
        drive_dp(dp_list[3]); step();
        drive_sp(sp_list[4]); reset_n_i = 1'b0; step();
        reset_n_i = 1'b1; v_i = 1'b0; ready_i = 1'b1; #1;
        check_val("midrst_v_o", 64'(v_o), 64'd0);
        check_val("midrst_ready_o", 64'(ready_o), 64'd1);
        drive_sp(sp_list[5]); step();
        v_i = 1'b0;
        step();
        check_val("midrst_resume_v_o", 64'(v_o), 64'd1);
        repeat (2) step();

        check_val("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
